spm_ex_dma: RTL

- Host-side initiator for the scratchpad external port.
- Takes a burst command (direction, start address, length, lane) and moves words between host streams and the scratchpad.
- Write bursts: drives write transactions onto the scratchpad's 42-bit external input bus.
- Read bursts: drives read transactions, captures the returned word from one 32-bit lane of the 128-bit external output bus, and buffers it in a credit-controlled FIFO so the host stream can apply backpressure.

---
 rtl/spm_ex_dma.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/spm_ex_dma.sv
// Host-side burst initiator for the scratchpad external port: streams host words
// into the SPM, or reads SPM words back through a credit-limited FWFT FIFO.
module spm_ex_dma #(
    parameter int A_W      = 8,
    parameter int D_W      = 32,
    parameter int LEN_W    = 9,
    parameter int RD_LAT   = 1,
    parameter int RF_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_dir,
    input  logic [A_W-1:0]       cmd_addr,
    input  logic [LEN_W-1:0]     cmd_len,
    input  logic [1:0]           cmd_lane,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [D_W-1:0]       wr_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [D_W-1:0]       rd_data,
    output logic [2+A_W+D_W-1:0] ex_in_bus,
    input  logic [4*D_W-1:0]     ex_out_bus,
    output logic                 busy,
    output logic                 done
);

    localparam int PW    = $clog2(RF_DEPTH);
    localparam int CNT_W = PW + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(256);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_FIN} state_t;

    state_t             r_state;
    logic [A_W-1:0]     r_cur;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   r_popped;
    logic [1:0]         r_lane;
    logic               r_wen;
    logic               r_ren;
    logic [A_W-1:0]     r_addr;
    logic [D_W-1:0]     r_data;
    logic [RD_LAT-1:0]  r_pipe;
    logic [D_W-1:0]     r_fifoMem [RF_DEPTH];
    logic [PW-1:0]      r_wptr;
    logic [PW-1:0]      r_rptr;
    logic [CNT_W-1:0]   r_fifoCnt;

    logic [LEN_W-1:0]   w_clampLen;
    logic               w_wrFire;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic [15:0]        w_used;
    logic [D_W-1:0]     w_laneWord;

    assign w_clampLen = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
    assign cmd_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_FIN);
    assign wr_ready   = (r_state == S_WR) && (r_cnt < r_len);
    assign w_wrFire   = wr_ready && wr_valid;
    assign rd_valid   = (r_fifoCnt != '0);
    assign rd_data    = rd_valid ? r_fifoMem[r_rptr] : '0;
    assign w_pop      = rd_valid && rd_ready;
    assign w_push     = r_pipe[RD_LAT-1];
    assign ex_in_bus  = {r_wen, r_ren, r_addr, r_data};

    // Credits cover every read already on the bus or in the latency pipe, so a
    // returning word always finds a free FIFO slot.
    always_comb begin
        w_used = 16'(r_fifoCnt) + 16'(r_ren);
        for (int i = 0; i < RD_LAT; i++) begin
            w_used = w_used + 16'(r_pipe[i]);
        end
        w_laneWord = '0;
        for (int k = 0; k < 4; k++) begin
            if (r_lane == 2'(k)) begin
                w_laneWord = ex_out_bus[k*D_W +: D_W];
            end
        end
    end

    assign w_issue = (r_state == S_RD) && (r_cnt < r_len) && (w_used < 16'(RF_DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cur    <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_popped <= '0;
            r_lane   <= '0;
            r_wen    <= 1'b0;
            r_ren    <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
        end else begin
            r_wen <= 1'b0;
            r_ren <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_cur    <= cmd_addr;
                        r_len    <= w_clampLen;
                        r_lane   <= cmd_lane;
                        r_cnt    <= '0;
                        r_popped <= '0;
                        if (w_clampLen == '0) begin
                            r_state <= S_FIN;
                        end else begin
                            r_state <= cmd_dir ? S_RD : S_WR;
                        end
                    end
                end
                S_WR: begin
                    if (w_wrFire) begin
                        r_wen  <= 1'b1;
                        r_addr <= r_cur;
                        r_data <= wr_data;
                        r_cur  <= r_cur + A_W'(1);
                        r_cnt  <= r_cnt + LEN_W'(1);
                        if (r_cnt + LEN_W'(1) == r_len) begin
                            r_state <= S_FIN;
                        end
                    end
                end
                S_RD: begin
                    if (w_issue) begin
                        r_ren  <= 1'b1;
                        r_addr <= r_cur;
                        r_cur  <= r_cur + A_W'(1);
                        r_cnt  <= r_cnt + LEN_W'(1);
                    end
                    if (w_pop) begin
                        r_popped <= r_popped + LEN_W'(1);
                        if (r_popped + LEN_W'(1) == r_len) begin
                            r_state <= S_FIN;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Read-return pipe and FIFO bookkeeping; push and pop may coincide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pipe    <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_fifoCnt <= '0;
        end else begin
            r_pipe[0] <= r_ren;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_fifoCnt <= r_fifoCnt + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifoMem[r_wptr] <= w_laneWord;
        end
    end

endmodule
